zero_cross_period_meter: RTL and testbench

Consumes the crossing pulse produced by the interpolator's zero-crossing detector and measures the interval between consecutive crossings.
- Interval is counted in sample strobes (enable cycles), not raw clocks.
- Averages 2^AVG_LOG2 intervals and publishes the result with a one-cycle valid pulse.
- Detects loss of signal (no crossing within MAX_COUNT samples) and re-arms.
- Sits downstream of the detector, on the same clk/enable sample cadence.

---
 rtl/zero_cross_period_meter.sv | 163 ++++++++++++++++
 tb/tb_zero_cross_period_meter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/zero_cross_period_meter.sv
// Measures the sample-strobe interval between detector crossings, averages 2^AVG_LOG2 of them, and flags loss of signal.
// Optional macro PERIOD_DEGLITCH_EN: reject crossings closer than MIN_INTERVAL samples and count them on glitch_cnt.
module zero_cross_period_meter #(
    parameter int unsigned   PW           = 24,
    parameter int unsigned   AVG_LOG2     = 2,
    parameter logic [PW-1:0] MAX_COUNT    = PW'(24'hFFFFFF),
    parameter int unsigned   MIN_INTERVAL = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          flag,
    output logic [PW-1:0] period,
    output logic          valid,
    output logic          locked,
    output logic          timeout
`ifdef PERIOD_DEGLITCH_EN
    ,
    output logic [7:0]    glitch_cnt
`endif
);

    localparam int unsigned AW = PW + AVG_LOG2;
    localparam int unsigned NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] NLAST = NW'((2 ** AVG_LOG2) - 1);
`ifdef PERIOD_DEGLITCH_EN
    localparam bit DEGLITCH_ON = 1'b1;
`else
    localparam bit DEGLITCH_ON = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [NW-1:0]   nint_q, nint_d;
    logic [PW-1:0]   period_q, period_d;
    logic            valid_q, valid_d;
    logic            locked_q, locked_d;
    logic            timeout_q, timeout_d;
`ifdef PERIOD_DEGLITCH_EN
    logic [7:0]      glitch_q, glitch_d;
`endif

    logic [PW-1:0]   interval_c;
    logic            hit_max_c;
    logic            is_glitch_c;
    logic            accept_c;
    logic            close_c;
    logic [AW-1:0]   sum_c;

    // Interval includes the strobe coinciding with the crossing; PW+1 bits guard the limit compare.
    always_comb begin
        interval_c  = cnt_q + PW'(enable);
        hit_max_c   = ({1'b0, cnt_q} + (PW+1)'(enable)) >= {1'b0, MAX_COUNT};
        is_glitch_c = DEGLITCH_ON && (interval_c < PW'(MIN_INTERVAL));
        accept_c    = flag && !is_glitch_c;
        close_c     = accept_c && (nint_q == NLAST);
        sum_c       = acc_q + AW'(interval_c);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An accepted crossing on the limit edge keeps the meter locked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flag) state_d = MEASURE;
            MEASURE: if (!accept_c && hit_max_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        nint_d    = nint_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        locked_d  = (state_d == MEASURE);
`ifdef PERIOD_DEGLITCH_EN
        glitch_d  = glitch_q;
`endif
        case (state_q)
            IDLE: begin
                if (flag) begin
                    cnt_d  = '0;
                    acc_d  = '0;
                    nint_d = '0;
                end
            end
            MEASURE: begin
                if (accept_c) begin
                    cnt_d = '0;
                    if (close_c) begin
                        period_d  = PW'(sum_c >> AVG_LOG2);
                        valid_d   = 1'b1;
                        acc_d     = '0;
                        nint_d    = '0;
                        timeout_d = 1'b0;
                    end else begin
                        acc_d  = sum_c;
                        nint_d = nint_q + NW'(1);
                    end
                end else begin
                    cnt_d = interval_c;
                    if (hit_max_c) begin
                        timeout_d = 1'b1;
                        acc_d     = '0;
                        nint_d    = '0;
                    end
                end
`ifdef PERIOD_DEGLITCH_EN
                if (flag && is_glitch_c && (glitch_q != 8'hFF)) glitch_d = glitch_q + 8'd1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            nint_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
`ifdef PERIOD_DEGLITCH_EN
            glitch_q  <= '0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            nint_q    <= nint_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
`ifdef PERIOD_DEGLITCH_EN
            glitch_q  <= glitch_d;
`endif
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;
`ifdef PERIOD_DEGLITCH_EN
    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_zero_cross_period_meter.sv
// Bench for zero_cross_period_meter: directed scenarios plus random crossings checked every cycle against an interval-list model.
module tb_zero_cross_period_meter;

    localparam int unsigned PW       = 24;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned NAVG     = 4;
    localparam int unsigned MAXC     = 50;
    localparam int unsigned MINIV    = 4;
`ifdef PERIOD_DEGLITCH_EN
    localparam bit DEG = 1'b1;
`else
    localparam bit DEG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          flag;
    logic [PW-1:0] period;
    logic          valid;
    logic          locked;
    logic          timeout;
`ifdef PERIOD_DEGLITCH_EN
    logic [7:0]    glitch_cnt;
`endif

    zero_cross_period_meter #(
        .PW(PW), .AVG_LOG2(AVG_LOG2), .MAX_COUNT(24'(MAXC)), .MIN_INTERVAL(MINIV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flag(flag),
        .period(period), .valid(valid), .locked(locked), .timeout(timeout)
`ifdef PERIOD_DEGLITCH_EN
        , .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Model: armed flag, samples since last crossing, list of closed intervals awaiting averaging.
    bit          m_armed   = 1'b0;
    int unsigned m_samples = 0;
    int unsigned m_ivq[$];
    int unsigned m_period  = 0;
    bit          m_valid   = 1'b0;
    bit          m_timeout = 1'b0;
    int unsigned m_glitch  = 0;

    always @(posedge clk) begin
        int unsigned iv;
        int unsigned sum;
        if (!reset_n) begin
            m_armed = 0; m_samples = 0; m_ivq.delete();
            m_period = 0; m_valid = 0; m_timeout = 0; m_glitch = 0;
        end else begin
            m_valid = 0;
            if (!m_armed) begin
                if (flag) begin
                    m_armed = 1; m_samples = 0; m_ivq.delete();
                end
            end else begin
                iv = m_samples + (enable ? 1 : 0);
                if (flag && !(DEG && iv < MINIV)) begin
                    m_ivq.push_back(iv);
                    m_samples = 0;
                    if (m_ivq.size() == NAVG) begin
                        sum = 0;
                        foreach (m_ivq[i]) sum += m_ivq[i];
                        m_period  = sum / NAVG;
                        m_valid   = 1;
                        m_timeout = 0;
                        m_ivq.delete();
                    end
                end else begin
                    if (flag && m_glitch < 255) m_glitch++;
                    m_samples = iv;
                    if (m_samples >= MAXC) begin
                        m_armed = 0; m_timeout = 1; m_ivq.delete();
                    end
                end
            end
        end
    end

    function automatic void check(input string name, input longint act, input longint exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            check("period", period, m_period);
            check("valid", valid, m_valid);
            check("locked", locked, m_armed);
            check("timeout", timeout, m_timeout);
`ifdef PERIOD_DEGLITCH_EN
            check("glitch_cnt", glitch_cnt, m_glitch);
`endif
        end
    end

    task automatic cyc(input bit en, input bit fl);
        enable = en;
        flag   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    // n enabled samples, the last one carrying the crossing.
    task automatic iv(input int n);
        repeat (n - 1) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
    endtask

    initial begin
        int mode;
        int len;
        int dens;
        reset_n = 1'b0; enable = 1'b0; flag = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk_en = 1'b1;
        check("rst_period", period, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
        reset_n = 1'b1;

        // Crossings at cycles 0,10,20,30,40 with enable held high.
        cyc(1'b1, 1'b1);
        check("t1_locked", locked, 1);
        repeat (4) iv(10);
        check("t1_valid", valid, 1);
        check("t1_period", period, 10);
        cyc(1'b1, 1'b0);
        check("t1_valid_once", valid, 0);

        // Enable every second cycle, crossing every 20 cycles.
        do_reset();
        for (int k = 0; k <= 100; k++) cyc((k % 2) == 0, (k % 20) == 0);
        check("t2_period", period, 10);

        // Truncating average of 10,11,11,11.
        do_reset();
        cyc(1'b1, 1'b1);
        iv(10); iv(11); iv(11); iv(11);
        check("t3_period", period, 10);

        // Crossing on the limit edge wins over timeout.
        do_reset();
        cyc(1'b1, 1'b1);
        iv(50);
        check("t4_edge_locked", locked, 1);
        check("t4_edge_timeout", timeout, 0);

        // Loss of signal after 50 samples, then re-arm.
        do_reset();
        cyc(1'b1, 1'b1);
        repeat (4) iv(12);
        check("t4_pre_period", period, 12);
        repeat (49) cyc(1'b1, 1'b0);
        check("t4_49_timeout", timeout, 0);
        cyc(1'b1, 1'b0);
        check("t4_timeout", timeout, 1);
        check("t4_unlocked", locked, 0);
        check("t4_period_held", period, 12);
        repeat (10) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check("t4_rearm_locked", locked, 1);
        check("t4_rearm_timeout", timeout, 1);
        repeat (4) iv(8);
        check("t4_period", period, 8);
        check("t4_cleared", timeout, 0);

        // Reset mid-accumulation discards the partial sum.
        do_reset();
        cyc(1'b1, 1'b1);
        repeat (3) iv(10);
        reset_n = 1'b0;
        cyc(1'b1, 1'b1);
        check("t5_rst_period", period, 0);
        check("t5_rst_locked", locked, 0);
        check("t5_rst_valid", valid, 0);
        reset_n = 1'b1;
        cyc(1'b1, 1'b1);
        repeat (4) iv(12);
        check("t5_period", period, 12);

        // Extra crossing two samples after each real one.
        do_reset();
        cyc(1'b1, 1'b1);
        repeat (4) begin iv(2); iv(8); end
`ifdef PERIOD_DEGLITCH_EN
        check("t6_period", period, 10);
        check("t6_glitch", glitch_cnt, 4);
`else
        check("t6_period", period, 5);
`endif

        // Random crossings, gaps, enable densities and occasional resets.
        do_reset();
        for (int b = 0; b < 500; b++) begin
            mode = $urandom_range(0, 19);
            dens = $urandom_range(1, 4);
            if (mode == 0)      len = $urandom_range(40, 80);
            else if (mode == 1) len = 0;
            else                len = $urandom_range(1, 16);
            if (mode == 2 && $urandom_range(0, 9) == 0) begin
                reset_n = 1'b0;
                cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                reset_n = 1'b1;
            end
            for (int k = 0; k < len; k++) cyc($urandom_range(1, 4) <= dens, 1'b0);
            cyc($urandom_range(1, 4) <= dens, 1'b1);
        end
        repeat (3) cyc(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
